// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction formats, loader states
// and the opcode/format legality rule used by the program loader.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

    // A bundle is legal only when the opcode is known and its format matches it.
    function automatic logic fmt_legal(input logic [5:0] op, input logic [1:0] fmt);
        case (op)
            OP_RTYPE:           return fmt == FMT_R;
            OP_J, OP_JAL:       return fmt == FMT_J;
            OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW:
                                return fmt == FMT_I;
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Host field-bundle handshake plus instruction-memory write port of the loader.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [5:0]        in_opcode;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational MIPS field-to-word packer; the legality flag exists only when
// INSTR_ENC_OPCODE_CHECK_EN is defined.
module instr_field_packer
    import mips_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
`ifdef INSTR_ENC_OPCODE_CHECK_EN
    output logic        legal,
`endif
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (fmt)
            FMT_I:   word = {opcode, rs, rt, imm};
            FMT_J:   word = {opcode, target};
            default: word = {opcode, rs, rt, rd, shamt, funct};
        endcase
    end

`ifdef INSTR_ENC_OPCODE_CHECK_EN
    assign legal = fmt_legal(opcode, fmt);
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes field bundles and writes them to instruction memory,
// holding the CPU in reset until done. INSTR_ENC_OPCODE_CHECK_EN enables validation.
module instr_encoder_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err
);

    loader_state_e     state;
    logic [ADDR_W-1:0] addr;
    logic              last_q;
    logic [31:0]       word;
`ifdef INSTR_ENC_OPCODE_CHECK_EN
    logic              legal;
`endif

    instr_field_packer u_packer (
        .fmt    (bus.in_fmt),
        .opcode (bus.in_opcode),
        .rs     (bus.in_rs),
        .rt     (bus.in_rt),
        .rd     (bus.in_rd),
        .shamt  (bus.in_shamt),
        .funct  (bus.in_funct),
        .imm    (bus.in_imm),
        .target (bus.in_target),
`ifdef INSTR_ENC_OPCODE_CHECK_EN
        .legal  (legal),
`endif
        .word   (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            addr           <= '0;
            last_q         <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.in_ready   <= 1'b0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        addr         <= '0;
                        err          <= 1'b0;
                        done         <= 1'b0;
                        cpu_hold     <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
`ifdef INSTR_ENC_OPCODE_CHECK_EN
                        // Illegal bundles are consumed without a write; a tagged-last one still ends the load.
                        if (!legal) begin
                            err <= 1'b1;
                            if (bus.in_last) begin
                                state        <= DONE;
                                done         <= 1'b1;
                                cpu_hold     <= 1'b0;
                                bus.in_ready <= 1'b0;
                            end
                        end else
`endif
                        begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= addr;
                            bus.imem_wdata <= word;
                            last_q         <= bus.in_last;
                            bus.in_ready   <= 1'b0;
                            state          <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (last_q || (addr == '1)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                        if (!last_q) err <= 1'b1;
                    end else begin
                        addr         <= addr + ADDR_W'(1);
                        state        <= LOAD;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed, table-driven bench for instr_encoder_loader (ADDR_W=8 and ADDR_W=2 instances).
module tb_instr_encoder_loader;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, start2;
    logic cpu_hold, done, err;
    logic cpu_hold2, done2, err2;

    instr_encoder_loader_if #(.ADDR_W(8)) bus  ();
    instr_encoder_loader_if #(.ADDR_W(2)) bus2 ();

    instr_encoder_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    instr_encoder_loader #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bus(bus2),
        .cpu_hold(cpu_hold2), .done(done2), .err(err2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
    wr_t wq[$];
    wr_t wq2[$];

    always @(negedge clk) begin
        if (bus.imem_we)  wq.push_back('{bus.imem_addr, bus.imem_wdata});
        if (bus2.imem_we) wq2.push_back('{{6'b0, bus2.imem_addr}, bus2.imem_wdata});
    end

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
        logic [7:0]  ea;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[8];
    vec_t v;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        bus.in_fmt    = x.fmt;
        bus.in_opcode = x.op;
        bus.in_rs     = x.rs;
        bus.in_rt     = x.rt;
        bus.in_rd     = x.rd;
        bus.in_shamt  = x.sh;
        bus.in_funct  = x.fn;
        bus.in_imm    = x.imm;
        bus.in_target = x.tgt;
        bus.in_last   = x.last;
    endtask

    // Entered and left on a falling edge; returns in the cycle after acceptance.
    task automatic send(input vec_t x);
        bit ok = 1'b0;
        drive(x);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.in_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("accept", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_write(input string nm, input logic [7:0] ea, input logic [31:0] ed);
        bit got = 1'b0;
        wr_t w;
        #2;
        for (int i = 0; i < 6 && !got; i++) begin
            if (wq.size() > 0) got = 1'b1;
            else #10;
        end
        check({nm, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            w = wq.pop_front();
            check({nm, "_addr"}, 32'(w.a), 32'(ea));
            check({nm, "_data"}, w.d, ed);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx, acc2;
        bit [5:0] rdy;
        wr_t w;

        //              fmt   op     rs    rt     rd     sh    fn     imm       tgt           last ea    ed
        tbl[0] = '{2'd1, 6'h08, 5'd0,  5'd8,  5'd0,  5'd0, 6'h00, 16'd5,    26'd0,        1'b1, 8'd0, 32'h20080005};
        tbl[1] = '{2'd0, 6'h00, 5'd8,  5'd9,  5'd10, 5'd0, 6'h20, 16'd0,    26'd0,        1'b0, 8'd0, 32'h01095020};
        tbl[2] = '{2'd1, 6'h23, 5'd29, 5'd8,  5'd0,  5'd0, 6'h00, 16'd4,    26'd0,        1'b0, 8'd1, 32'h8FA80004};
        tbl[3] = '{2'd2, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'd0,    26'h10,       1'b1, 8'd2, 32'h08000010};
        tbl[4] = '{2'd1, 6'h2B, 5'd9,  5'd16, 5'd0,  5'd0, 6'h00, 16'hFFF8, 26'd0,        1'b0, 8'd0, 32'hAD30FFF8};
        tbl[5] = '{2'd0, 6'h00, 5'd0,  5'd9,  5'd8,  5'd4, 6'h00, 16'd0,    26'd0,        1'b0, 8'd1, 32'h00094100};
        tbl[6] = '{2'd2, 6'h03, 5'd7,  5'd7,  5'd0,  5'd0, 6'h00, 16'hFFFF, 26'h3FFFFFF,  1'b0, 8'd2, 32'h0FFFFFFF};
        tbl[7] = '{2'd1, 6'h04, 5'd8,  5'd9,  5'd31, 5'd31,6'h3F, 16'h0010, 26'h3FFFFFF,  1'b1, 8'd3, 32'h11090010};

        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
        drive(tbl[0]);
        bus2.in_fmt = 2'd1; bus2.in_opcode = 6'h08; bus2.in_rs = '0; bus2.in_rt = '0;
        bus2.in_rd = '0; bus2.in_shamt = '0; bus2.in_funct = '0; bus2.in_imm = '0;
        bus2.in_target = '0; bus2.in_last = 1'b0;

        @(negedge clk);
        check("rst_we",    32'(bus.imem_we),  32'd0);
        check("rst_addr",  32'(bus.imem_addr), 32'd0);
        check("rst_wdata", bus.imem_wdata,    32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_hold",  32'(cpu_hold),     32'd1);
        check("rst_done",  32'(done),         32'd0);
        check("rst_err",   32'(err),          32'd0);
        @(negedge clk);
        reset = 1'b0;

        // in_valid in IDLE is ignored
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        check("idle_no_write", 32'(wq.size()), 32'd0);
        check("idle_hold", 32'(cpu_hold), 32'd1);

        // Table: three programs back to back (addi; add/lw/j; sw/sll/jal/beq)
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || tbl[i-1].last) begin
                pulse_start();
                check("start_ready", 32'(bus.in_ready), 32'd1);
                check("start_hold",  32'(cpu_hold),     32'd1);
                check("start_done",  32'(done),         32'd0);
            end
            send(tbl[i]);
            expect_write($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].ed);
            if (tbl[i].last) begin
                check("end_done",  32'(done),         32'd1);
                check("end_hold",  32'(cpu_hold),     32'd0);
                check("end_err",   32'(err),          32'd0);
                check("end_ready", 32'(bus.in_ready), 32'd0);
                check("end_extra", 32'(wq.size()),    32'd0);
            end
        end

        // start coincident with in_valid in DONE: bundle not taken that cycle
        drive(tbl[0]);
        bus.in_valid = 1'b1;
        pulse_start();
        check("coin_ready", 32'(bus.in_ready), 32'd1);
        check("coin_nowr",  32'(wq.size()),    32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_write("coin", 8'd0, 32'h20080005);
        repeat (2) @(negedge clk);
        check("coin_single", 32'(wq.size()), 32'd0);

        // Backpressure: valid held high, ready alternates 1,0
        pulse_start();
        idx = 1;
        drive(tbl[1]);
        bus.in_valid = 1'b1;
        rdy = '0;
        for (int c = 0; c < 8; c++) begin
            if (c < 6) rdy[c] = bus.in_ready;
            if (bus.in_ready) begin
                idx++;
                @(negedge clk);
                if (idx <= 3) drive(tbl[idx]);
            end else begin
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        check("bp_ready_pat", 32'(rdy), 32'b010101);
        check("bp_count", 32'(wq.size()), 32'd3);
        for (int k = 1; k <= 3; k++) begin
            if (wq.size() > 0) begin
                w = wq.pop_front();
                check($sformatf("bp%0d_addr", k), 32'(w.a), 32'(tbl[k].ea));
                check($sformatf("bp%0d_data", k), w.d, tbl[k].ed);
            end
        end
        check("bp_done", 32'(done), 32'd1);

        // Overflow on the ADDR_W=2 instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bus2.in_valid = 1'b1;
        acc2 = 0;
        for (int c = 0; c < 16; c++) begin
            if (bus2.in_ready) begin
                acc2++;
                @(posedge clk);
                #1 bus2.in_imm = 16'(acc2);
            end
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
        check("ovf_accepts", 32'(acc2), 32'd4);
        check("ovf_writes", 32'(wq2.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (wq2.size() > 0) begin
                w = wq2.pop_front();
                check($sformatf("ovf%0d_addr", k), 32'(w.a), 32'(k));
                check($sformatf("ovf%0d_data", k), w.d, 32'h20000000 | 32'(k));
            end
        end
        check("ovf_err",   32'(err2),          32'd1);
        check("ovf_done",  32'(done2),         32'd1);
        check("ovf_hold",  32'(cpu_hold2),     32'd0);
        check("ovf_ready", 32'(bus2.in_ready), 32'd0);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("ovf_err_clr",  32'(err2),      32'd0);
        check("ovf_done_clr", 32'(done2),     32'd0);
        check("ovf_rehold",   32'(cpu_hold2), 32'd1);

`ifdef INSTR_ENC_OPCODE_CHECK_EN
        pulse_start();
        v = '{2'd2, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'd5, 26'd0, 1'b0, 8'd0, 32'd0};
        send(v);
        repeat (2) @(negedge clk);
        check("chk_nowrite", 32'(wq.size()), 32'd0);
        check("chk_err", 32'(err), 32'd1);
        check("chk_ready", 32'(bus.in_ready), 32'd1);
        send(tbl[0]);
        expect_write("chk_legal", 8'd0, 32'h20080005);
        check("chk_err_sticky", 32'(err), 32'd1);
        check("chk_done", 32'(done), 32'd1);
        pulse_start();
        check("chk_err_clr", 32'(err), 32'd0);
        v.last = 1'b1;
        send(v);
        @(negedge clk);
        check("chk_last_done", 32'(done), 32'd1);
        check("chk_last_err", 32'(err), 32'd1);
        check("chk_last_nowr", 32'(wq.size()), 32'd0);
`else
        pulse_start();
        v = '{2'd3, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'hABCD, 26'h155, 1'b1, 8'd0, 32'hFC221905};
        send(v);
        expect_write("fmt3", v.ea, v.ed);
        check("fmt3_err", 32'(err), 32'd0);
        check("fmt3_done", 32'(done), 32'd1);
`endif

        // Reset mid-load after two writes, then reload from address 0
        pulse_start();
        send(tbl[1]);
        expect_write("mid0", 8'd0, tbl[1].ed);
        send(tbl[2]);
        expect_write("mid1", 8'd1, tbl[2].ed);
        reset = 1'b1;
        #1;
        check("mid_hold",  32'(cpu_hold),     32'd1);
        check("mid_ready", 32'(bus.in_ready), 32'd0);
        check("mid_done",  32'(done),         32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_idle_ready", 32'(bus.in_ready), 32'd0);
        pulse_start();
        send(tbl[4]);
        expect_write("rl0", 8'd0, tbl[4].ed);
        send(tbl[0]);
        expect_write("rl1", 8'd1, tbl[0].ed);
        check("rl_done", 32'(done), 32'd1);
        check("rl_hold", 32'(cpu_hold), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
